// File: rtl/dpram_wr_arb.sv
// rtl/dpram_wr_arb.sv - two-requester round-robin write arbiter for a frame RAM port A,
// with a full zero-fill clear sequence that takes priority over pending requests.
module dpram_wr_arb #(
  parameter int AW = 11,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          r0_req,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_data,
  output logic          r0_ack,
  input  logic          r1_req,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_data,
  output logic          r1_ack,
  input  logic          clr_start,
  output logic          clr_busy,
  output logic          wea,
  output logic [AW-1:0] addra,
  output logic [DW-1:0] dia
);

  typedef enum logic [1:0] {IDLE, WR, CLR} state_t;

  state_t        state_q;
  logic          pend_q;
  logic          last_q;
  logic [AW-1:0] cnt_q;
  logic          wea_q;
  logic [AW-1:0] addra_q;
  logic [DW-1:0] dia_q;
  logic          r0_ack_q;
  logic          r1_ack_q;
  logic          clr_busy_q;

  logic          any_req_d;
  logic          grant1_d;

  // On a tie the requester that did not win last time gets the slot.
  always_comb begin
    any_req_d = r0_req | r1_req;
    grant1_d  = r1_req & (~r0_req | ~last_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      pend_q     <= 1'b0;
      last_q     <= 1'b1;
      cnt_q      <= '0;
      wea_q      <= 1'b0;
      addra_q    <= '0;
      dia_q      <= '0;
      r0_ack_q   <= 1'b0;
      r1_ack_q   <= 1'b0;
      clr_busy_q <= 1'b0;
    end else begin
      wea_q    <= 1'b0;
      r0_ack_q <= 1'b0;
      r1_ack_q <= 1'b0;
      if (clr_start && state_q != CLR) begin
        pend_q     <= 1'b1;
        clr_busy_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (pend_q) begin
            state_q    <= CLR;
            pend_q     <= clr_start;
            cnt_q      <= '0;
            wea_q      <= 1'b1;
            addra_q    <= '0;
            dia_q      <= '0;
            clr_busy_q <= 1'b1;
          end else if (any_req_d) begin
            state_q  <= WR;
            last_q   <= grant1_d;
            wea_q    <= 1'b1;
            addra_q  <= grant1_d ? r1_addr : r0_addr;
            dia_q    <= grant1_d ? r1_data : r0_data;
            r0_ack_q <= ~grant1_d;
            r1_ack_q <= grant1_d;
          end
        end
        WR: begin
          // Forced turnaround so a requester sees its ack before being sampled again.
          state_q <= IDLE;
        end
        CLR: begin
          if (cnt_q == {AW{1'b1}}) begin
            state_q    <= IDLE;
            clr_busy_q <= pend_q;
          end else begin
            cnt_q   <= cnt_q + 1'b1;
            wea_q   <= 1'b1;
            addra_q <= cnt_q + 1'b1;
            dia_q   <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wea      = wea_q;
  assign addra    = addra_q;
  assign dia      = dia_q;
  assign r0_ack   = r0_ack_q;
  assign r1_ack   = r1_ack_q;
  assign clr_busy = clr_busy_q;

endmodule

// File: tb/tb_dpram_wr_arb.sv
// tb/tb_dpram_wr_arb.sv - directed self-checking bench for dpram_wr_arb.
module tb_dpram_wr_arb;
  localparam int AW = 11;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          r0_req, r1_req;
  logic [AW-1:0] r0_addr, r1_addr;
  logic [DW-1:0] r0_data, r1_data;
  logic          r0_ack, r1_ack;
  logic          clr_start, clr_busy;
  logic          wea;
  logic [AW-1:0] addra;
  logic [DW-1:0] dia;

  int tests = 0;
  int fails = 0;

  dpram_wr_arb #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .r0_req(r0_req), .r0_addr(r0_addr), .r0_data(r0_data), .r0_ack(r0_ack),
    .r1_req(r1_req), .r1_addr(r1_addr), .r1_data(r1_data), .r1_ack(r1_ack),
    .clr_start(clr_start), .clr_busy(clr_busy),
    .wea(wea), .addra(addra), .dia(dia)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Packs {wea, addra, dia, r0_ack, r1_ack, clr_busy} for one-shot comparison.
  function automatic logic [31:0] pk(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                                     input logic k0, input logic k1, input logic b);
    return {8'd0, w, 1'b0, a, d, k0, k1, b, 1'b0};
  endfunction

  function automatic logic [31:0] outs();
    return pk(wea, addra, dia, r0_ack, r1_ack, clr_busy);
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int errs;
    reset = 1'b1; r0_req = 0; r1_req = 0; r0_addr = 0; r1_addr = 0;
    r0_data = 0; r1_data = 0; clr_start = 0;
    tick(); tick();
    chk("reset_state", outs(), pk(0, 11'h000, 8'h00, 0, 0, 0));
    reset = 1'b0;

    // Both requesting from reset: r0 first, then r1 after turnaround.
    r0_req = 1; r0_addr = 11'h010; r0_data = 8'hA0;
    r1_req = 1; r1_addr = 11'h020; r1_data = 8'hB1;
    tick(); chk("tie1_r0", outs(), pk(1, 11'h010, 8'hA0, 1, 0, 0));
    r0_req = 0;
    tick(); chk("tie1_idle", outs(), pk(0, 11'h010, 8'hA0, 0, 0, 0));
    tick(); chk("tie1_r1", outs(), pk(1, 11'h020, 8'hB1, 0, 1, 0));
    r1_req = 0;
    tick();
    r0_req = 1; r1_req = 1;
    tick(); chk("tie2_r0", outs(), pk(1, 11'h010, 8'hA0, 1, 0, 0));
    r0_req = 0;
    tick(); tick(); chk("tie2_r1", outs(), pk(1, 11'h020, 8'hB1, 0, 1, 0));
    r1_req = 0;
    tick();
    // After r0 alone, a tie goes to r1.
    r0_req = 1;
    tick(); chk("solo_r0", outs(), pk(1, 11'h010, 8'hA0, 1, 0, 0));
    r0_req = 0; tick();
    r0_req = 1; r1_req = 1;
    tick(); chk("tie3_r1", outs(), pk(1, 11'h020, 8'hB1, 0, 1, 0));
    r1_req = 0;
    tick(); tick(); chk("tie3_r0", outs(), pk(1, 11'h010, 8'hA0, 1, 0, 0));
    r0_req = 0; tick();

    // Single write from a fresh reset.
    do_reset();
    r0_req = 1; r0_addr = 11'h005; r0_data = 8'h43;
    tick(); chk("wr_basic", outs(), pk(1, 11'h005, 8'h43, 1, 0, 0));
    r0_req = 0;
    tick(); chk("wr_hold1", outs(), pk(0, 11'h005, 8'h43, 0, 0, 0));
    tick(); chk("wr_hold2", outs(), pk(0, 11'h005, 8'h43, 0, 0, 0));

    // r1 held high; new data after each ack, one write per two cycles.
    r1_req = 1; r1_addr = 11'h100; r1_data = 8'h50;
    for (int i = 0; i < 3; i++) begin
      tick(); chk("stream_wr", outs(), pk(1, 11'h100 + 11'(i), 8'h50 + 8'(i), 0, 1, 0));
      r1_addr = 11'h101 + 11'(i); r1_data = 8'h51 + 8'(i);
      tick(); chk("stream_gap", outs(), pk(0, 11'h100 + 11'(i), 8'h50 + 8'(i), 0, 0, 0));
    end
    r1_req = 0; tick();

    // Full clear with a request arriving mid-clear.
    clr_start = 1;
    tick(); clr_start = 0;
    chk("clr_pend", outs(), pk(0, 11'h102, 8'h52, 0, 0, 1));
    tick(); chk("clr_first", outs(), pk(1, 11'h000, 8'h00, 0, 0, 1));
    errs = 0;
    for (int k = 1; k < 2048; k++) begin
      if (k == 1000) begin
        r0_req = 1; r0_addr = 11'h033; r0_data = 8'h77;
      end
      tick();
      if (outs() !== pk(1, 11'(k), 8'h00, 0, 0, 1)) errs++;
    end
    chk("clr_sweep_errs", errs, 0);
    tick(); chk("clr_done", outs(), pk(0, 11'h7FF, 8'h00, 0, 0, 0));
    tick(); chk("clr_then_r0", outs(), pk(1, 11'h033, 8'h77, 1, 0, 0));
    r0_req = 0; tick();

    // clr_start during WR: WR finishes, one idle cycle, then clear from 0.
    r0_req = 1; r0_addr = 11'h044; r0_data = 8'h12;
    tick(); chk("wr_before_clr", outs(), pk(1, 11'h044, 8'h12, 1, 0, 0));
    r0_req = 0; clr_start = 1;
    tick(); clr_start = 0;
    chk("clr_after_wr_idle", outs(), pk(0, 11'h044, 8'h12, 0, 0, 1));
    tick(); chk("clr_after_wr_first", outs(), pk(1, 11'h000, 8'h00, 0, 0, 1));
    for (int k = 1; k <= 256; k++) tick();
    chk("clr_at_100", outs(), pk(1, 11'h100, 8'h00, 0, 0, 1));

    // Reset mid-clear aborts it.
    reset = 1;
    tick(); chk("clr_abort", outs(), pk(0, 11'h000, 8'h00, 0, 0, 0));
    reset = 0;
    errs = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (wea !== 1'b0 || clr_busy !== 1'b0) errs++;
    end
    chk("no_writes_after_abort", errs, 0);
    r0_req = 1; r0_addr = 11'h7FF; r0_data = 8'h21;
    tick(); chk("wr_7ff", outs(), pk(1, 11'h7FF, 8'h21, 1, 0, 0));
    r0_req = 0; tick(); tick();

    // Reset coinciding with clr_start and a request discards both.
    reset = 1; clr_start = 1; r1_req = 1;
    tick(); reset = 0; clr_start = 0; r1_req = 0;
    chk("rst_wins_1", outs(), pk(0, 11'h000, 8'h00, 0, 0, 0));
    tick(); chk("rst_wins_2", outs(), pk(0, 11'h000, 8'h00, 0, 0, 0));
    tick(); chk("rst_wins_3", outs(), pk(0, 11'h000, 8'h00, 0, 0, 0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
